mux_sel_arbiter: RTL and testbench
==================================

Name: mux_sel_arbiter

Overview:
- Round-robin arbiter that shares one 32:1 bit-select mux (mux32to1) among 32 requesters. It drives the mux's 5-bit sel.
- The mux is built from gate-level 2:1 stages, each with a propagation delay of 50 per gate. The arbiter therefore waits a programmable number of settle cycles after every sel change before it flags the mux output valid.
- Sits beside mux32to1 in the CPU datapath. Requesters hold req until they assert done.

Parameters:
- N_REQ, 32, number of requesters; fixed to the mux width.
- SEL_W, 5, select width, log2(N_REQ).
- SETTLE, 2, cycles to wait after sel changes before data_valid; 0 means valid in the first GRANT cycle.
- MAX_HOLD, 0, maximum cycles a grant may be held in GRANT; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  32  request vector; bit i means requester i wants the mux.
- done  in  1  current owner releases the mux; sampled only in GRANT.
- sel  out  5  mux select; registered.
- grant  out  32  one-hot owner indicator; registered; all zero when idle.
- data_valid  out  1  mux output has settled for the current sel.
- busy  out  1  state is not IDLE.
- timeout  out  1  one-cycle pulse when MAX_HOLD forces a release.

Behaviour:
- Reset (async assert, sync deassert by clk): state=IDLE, sel=0, grant=0, data_valid=0, busy=0, timeout=0, ptr=0, settle counter=0, hold counter=0.
- ptr is the round-robin start index, 5 bits, modulo 32.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner w: the first set bit scanning from ptr upward with wrap 31->0.
  - Next cycle: sel=w, grant=1<<w, settle counter=SETTLE.
  - Go to SETTLE if SETTLE>0, else to GRANT.
  - Request-to-grant latency is 1 cycle.
- SETTLE:
  - Decrement the counter each cycle; data_valid=0.
  - When the counter reaches 1, go to GRANT.
  - If req[sel] drops here, abort: go to IDLE, grant=0, ptr unchanged.
- GRANT:
  - data_valid=1; hold counter increments each cycle.
  - Release condition: done=1, or req[sel]=0, or (MAX_HOLD!=0 and hold counter==MAX_HOLD-1).
  - On release: next cycle grant=0, data_valid=0, ptr=sel+1 (31 wraps to 0), state=IDLE. sel keeps its last value.
  - timeout pulses for one cycle only if the release was caused solely by MAX_HOLD.
- Release always costs one IDLE bubble cycle, so a back-to-back grant appears 2 cycles after done.
- req bits other than the owner's are ignored outside IDLE.
- done outside GRANT is ignored.
- Reset asserted mid-operation clears everything immediately: grant=0 and data_valid=0 asynchronously.
- A lone requester can be re-granted repeatedly, since ptr advancing past it still wraps back to it.
- Starvation-free: any requester that holds req is granted within 31 grants.

Decomposition:
- Shared include mux_arb_defs.vh holds:
  - state encodings: IDLE=2'd0, SETTLE=2'd1, GRANT=2'd2;
  - SEL_W/N_REQ constants.
- One combinational sub-module, rr_pick32:
  - inputs: req[31:0], ptr[4:0];
  - outputs: idx[4:0] and any.
  - Implemented as a rotate, priority encode, then un-rotate.
- The FSM, counters and output registers stay in mux_sel_arbiter.

Test Plan:
1. Reset then idle: hold rst_n=0 with req=32'hFFFF_FFFF, then release with req=0 → grant=0, sel=0, busy=0 for 5 cycles.
2. Single request, SETTLE=2:
   - req=1<<7 at cycle 0 → cycle 1: sel=7, grant=32'h80, data_valid=0.
   - data_valid=1 from cycle 3.
   - done at cycle 5 → cycle 6: grant=0, state IDLE.
3. Round-robin fairness: req=32'h8000_0003 held, done pulsed in every GRANT → grant order 0, 1, 31, 0, 1, 31; sel wrap 31→0 verified.
4. Abort in SETTLE: req[4] granted, req[4] dropped one cycle later → IDLE next cycle, data_valid never 1, ptr still 0 (the next req=32'h10 is granted again to 4).
5. Timeout, MAX_HOLD=4, SETTLE=0: req[9] held, done=0 → data_valid high 4 cycles, timeout pulses one cycle, grant=0, next winner after 9.
6. Async reset mid-GRANT: rst_n dropped between clock edges → grant, data_valid, busy go to 0 without a clock edge; after rst_n rises, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/mux_sel_arbiter_pkg.sv
// Shared constants and state encoding for the mux32to1 select arbiter.
package mux_sel_arbiter_pkg;

   localparam int N_REQ  = 32;
   localparam int SEL_W  = 5;
   localparam int CNT_W  = 8;
   localparam int HOLD_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_GRANT  = 2'd2
   } state_e;

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Round-robin picker: rotate by ptr, find lowest set bit, rotate back.
module rr_pick32
   import mux_sel_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] idx,
   output logic             any
);

   logic [N_REQ-1:0] rot;
   logic [SEL_W-1:0] off;

   // A shift by 32 (ptr==0) yields zero, so no special case is needed.
   assign rot = (req >> ptr) | (req << (6'd32 - {1'b0, ptr}));

   always_comb begin
      off = '0;
      for (int i = N_REQ-1; i >= 0; i--) begin
         if (rot[i]) off = SEL_W'(i);
      end
   end

   assign idx = off + ptr;
   assign any = |req;

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of the shared 32:1 mux select, with settle and hold timing.
module mux_sel_arbiter
   import mux_sel_arbiter_pkg::*;
#(
   parameter int SETTLE   = 2,
   parameter int MAX_HOLD = 0
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [SEL_W-1:0] sel,
   output logic [N_REQ-1:0] grant,
   output logic             data_valid,
   output logic             busy,
   output logic             timeout
);

   state_e            state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [SEL_W-1:0]  ptr_q, ptr_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              timeout_q, timeout_d;

   logic [SEL_W-1:0]  win;
   logic              any;
   logic              own_req;
   logic              hold_hit;

   rr_pick32 u_pick (
      .req (req),
      .ptr (ptr_q),
      .idx (win),
      .any (any)
   );

   assign own_req  = req[sel_q];
   assign hold_hit = (MAX_HOLD != 0) &&
                     (hold_q == HOLD_W'(MAX_HOLD - 1));

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (any) begin
               sel_d   = win;
               grant_d = N_REQ'(1) << win;
               cnt_d   = CNT_W'(SETTLE);
               hold_d  = '0;
               state_d = (SETTLE > 0) ? ST_SETTLE : ST_GRANT;
            end
         end
         ST_SETTLE: begin
            if (!own_req) begin
               // Abort leaves ptr alone so the same winner stays first.
               state_d = ST_IDLE;
               grant_d = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q <= CNT_W'(1)) state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            hold_d = hold_q + HOLD_W'(1);
            if (done || !own_req || hold_hit) begin
               state_d   = ST_IDLE;
               grant_d   = '0;
               ptr_d     = sel_q + SEL_W'(1);
               timeout_d = hold_hit && !done && own_req;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         sel_q     <= '0;
         ptr_q     <= '0;
         grant_q   <= '0;
         cnt_q     <= '0;
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign sel        = sel_q;
   assign grant      = grant_q;
   assign data_valid = (state_q == ST_GRANT);
   assign busy       = (state_q != ST_IDLE);
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench: settle/abort/round-robin on one instance, timeout on another.
module tb_mux_sel_arbiter;

   logic        clk;
   logic        rst_n;
   logic [31:0] req_a, req_b;
   logic        done_a, done_b;
   logic [4:0]  sel_a, sel_b;
   logic [31:0] grant_a, grant_b;
   logic        dv_a, dv_b;
   logic        busy_a, busy_b;
   logic        to_a, to_b;

   int total = 0;
   int bad   = 0;

   mux_sel_arbiter #(.SETTLE(2), .MAX_HOLD(0)) u_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req_a),
      .done       (done_a),
      .sel        (sel_a),
      .grant      (grant_a),
      .data_valid (dv_a),
      .busy       (busy_a),
      .timeout    (to_a)
   );

   mux_sel_arbiter #(.SETTLE(0), .MAX_HOLD(4)) u_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req_b),
      .done       (done_b),
      .sel        (sel_b),
      .grant      (grant_b),
      .data_valid (dv_b),
      .busy       (busy_b),
      .timeout    (to_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   int          rr_exp [6] = '{0, 1, 31, 0, 1, 31};
   logic [31:0] one = 32'd1;

   initial begin
      rst_n  = 1'b0;
      req_a  = '1;
      req_b  = '1;
      done_a = 1'b0;
      done_b = 1'b0;
      repeat (3) tick();
      chk("rst_grant", grant_a, 32'h0);
      chk("rst_dv", 32'(dv_a), 32'h0);
      chk("rst_busy", 32'(busy_a), 32'h0);
      chk("rst_to_b", 32'(to_b), 32'h0);

      rst_n = 1'b1;
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_grant", grant_a, 32'h0);
         chk("idle_sel", 32'(sel_a), 32'h0);
         chk("idle_busy", 32'(busy_a), 32'h0);
      end

      // single request with two settle cycles
      req_a = 32'h80;
      tick();
      chk("s_sel", 32'(sel_a), 32'd7);
      chk("s_grant", grant_a, 32'h80);
      chk("s_dv1", 32'(dv_a), 32'h0);
      chk("s_busy", 32'(busy_a), 32'h1);
      tick();
      chk("s_dv2", 32'(dv_a), 32'h0);
      tick();
      chk("s_dv3", 32'(dv_a), 32'h1);
      tick();
      chk("s_dv4", 32'(dv_a), 32'h1);
      tick();
      chk("s_dv5", 32'(dv_a), 32'h1);
      done_a = 1'b1;
      tick();
      chk("s_rel_grant", grant_a, 32'h0);
      chk("s_rel_dv", 32'(dv_a), 32'h0);
      chk("s_rel_busy", 32'(busy_a), 32'h0);
      chk("s_rel_sel", 32'(sel_a), 32'd7);
      done_a = 1'b0;
      req_a  = '0;

      // round robin from ptr 0 with wrap
      do_reset();
      req_a = 32'h8000_0003;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rr_sel", 32'(sel_a), 32'(rr_exp[k]));
         chk("rr_grant", grant_a, one << rr_exp[k]);
         tick();
         tick();
         chk("rr_dv", 32'(dv_a), 32'h1);
         done_a = 1'b1;
         tick();
         done_a = 1'b0;
         chk("rr_rel", grant_a, 32'h0);
      end
      req_a = '0;
      tick();

      // abort during settle keeps ptr
      req_a = 32'h10;
      tick();
      chk("ab_sel", 32'(sel_a), 32'd4);
      chk("ab_grant", grant_a, 32'h10);
      chk("ab_dv1", 32'(dv_a), 32'h0);
      req_a = '0;
      tick();
      chk("ab_grant0", grant_a, 32'h0);
      chk("ab_busy", 32'(busy_a), 32'h0);
      chk("ab_dv2", 32'(dv_a), 32'h0);
      req_a = 32'h30;
      tick();
      chk("ab_resel", 32'(sel_a), 32'd4);
      chk("ab_regrant", grant_a, 32'h10);
      req_a = '0;
      tick();
      chk("ab_end", grant_a, 32'h0);
      tick();

      // hold timeout on the second instance
      req_b = 32'h200;
      tick();
      chk("to_grant", grant_b, 32'h200);
      chk("to_sel", 32'(sel_b), 32'd9);
      chk("to_dv", 32'(dv_b), 32'h1);
      chk("to_early", 32'(to_b), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("to_hold_dv", 32'(dv_b), 32'h1);
         chk("to_hold_to", 32'(to_b), 32'h0);
         chk("to_hold_g", grant_b, 32'h200);
      end
      req_b = 32'h208;
      tick();
      chk("to_rel_grant", grant_b, 32'h0);
      chk("to_rel_dv", 32'(dv_b), 32'h0);
      chk("to_pulse", 32'(to_b), 32'h1);
      tick();
      chk("to_pulse_end", 32'(to_b), 32'h0);
      chk("to_next_sel", 32'(sel_b), 32'd3);
      chk("to_next_g", grant_b, 32'h8);
      req_b = '0;
      tick();
      chk("to_drop_g", grant_b, 32'h0);
      chk("to_drop_to", 32'(to_b), 32'h0);

      // lone requester regrant, then async reset mid-grant
      do_reset();
      req_a = 32'h4;
      tick();
      tick();
      tick();
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      tick();
      chk("lone_sel", 32'(sel_a), 32'd2);
      chk("lone_grant", grant_a, 32'h4);
      tick();
      tick();
      chk("lone_dv", 32'(dv_a), 32'h1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_grant", grant_a, 32'h0);
      chk("ar_dv", 32'(dv_a), 32'h0);
      chk("ar_busy", 32'(busy_a), 32'h0);
      req_a = 32'h12;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("ar_sel", 32'(sel_a), 32'd1);
      chk("ar_regrant", grant_a, 32'h2);
      req_a = '0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
